// File: rtl/polyvec_pair_loader.sv
// polyvec_pair_loader: packs a ready/valid stream of 16-bit coefficients into
// (even, odd) pairs and presents them to one operand port of the polyvec
// basemul/accumulate stage. Each pair carries its even index and poly select.
// A one-cycle full_in pulse follows the final pair of the polyvec.
module polyvec_pair_loader #(
  parameter int DEPTH   = 8,
  parameter int KYBER_K = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             dst_ok,
  output logic             readin,
  output logic [15:0]      din_1,
  output logic [15:0]      din_2,
  output logic [DEPTH-1:0] index,
  output logic [3:0]       k,
  output logic             full_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

  // Highest even index in a poly (N-2) and the last poly select.
  localparam logic [DEPTH-1:0] LAST_INDEX = {{(DEPTH-1){1'b1}}, 1'b0};
  localparam logic [DEPTH-1:0] INDEX_STEP = DEPTH'(2);
  localparam logic [3:0]       LAST_K     = 4'(KYBER_K - 1);

  state_t      state;
  logic        half;        // one coefficient of the next pair held in lo_r
  logic        pair_valid;  // din_1/din_2 hold a pair not yet written
  logic [15:0] lo_r;

  logic wr_fire;
  logic last_fire;
  logic accept;

  // A presented pair completes when the consumer is ready and the clock is enabled.
  assign wr_fire   = pair_valid & dst_ok & set;
  assign last_fire = wr_fire & (index == LAST_INDEX) & (k == LAST_K);

  // Room exists unless a full pair is stuck and the half slot is already taken.
  // The final write closes the window, so nothing is taken in that cycle.
  assign s_ready = set & (state == LOAD) & (~half | ~pair_valid | wr_fire) & ~last_fire;
  assign accept  = s_valid & s_ready;

  assign readin = pair_valid;
  assign busy   = (state == LOAD) | (state == FULL);
  assign done   = (state == DONE);

  // Load FSM, coefficient packing and pair addressing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      half       <= 1'b0;
      pair_valid <= 1'b0;
      lo_r       <= '0;
      din_1      <= '0;
      din_2      <= '0;
      index      <= '0;
      k          <= '0;
      full_in    <= 1'b0;
    end else if (set) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            index      <= '0;
            k          <= '0;
            half       <= 1'b0;
            pair_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (!half) begin
              lo_r <= s_data;
              half <= 1'b1;
            end else begin
              // A completing accept replaces any pair written this cycle,
              // so pair_valid stays high without a bubble.
              din_1      <= lo_r;
              din_2      <= s_data;
              pair_valid <= 1'b1;
              half       <= 1'b0;
            end
          end
          if (wr_fire && !(accept && half)) begin
            pair_valid <= 1'b0;
          end
          if (last_fire) begin
            // index and k keep their final values for the consumer.
            state   <= FULL;
            full_in <= 1'b1;
          end else if (wr_fire) begin
            index <= index + INDEX_STEP;
            if (index == LAST_INDEX) begin
              k <= k + 4'd1;
            end
          end
        end
        FULL: begin
          full_in <= 1'b0;
          state   <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polyvec_pair_loader.sv
// Testbench for polyvec_pair_loader: randomized streams checked against a
// pair/index/poly model derived directly from the coefficient order.
module tb_polyvec_pair_loader;

  localparam int DEPTH = 8;
  localparam int KK    = 3;
  localparam int N     = 1 << DEPTH;
  localparam int NC    = KK * N;
  localparam int NP    = NC / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             set;
  logic             start;
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             dst_ok;
  logic             readin;
  logic [15:0]      din_1;
  logic [15:0]      din_2;
  logic [DEPTH-1:0] index;
  logic [3:0]       k;
  logic             full_in;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [DEPTH-1:0] idx;
    logic [3:0]       kk;
  } wr_t;

  logic [15:0] src [NC];
  int          sent;
  wr_t         wr_q [$];
  wr_t         exp_q [$];
  int          full_cnt;
  int          stall_cnt;

  always #5 clk = ~clk;

  polyvec_pair_loader #(.DEPTH(DEPTH), .KYBER_K(KK)) dut (
    .clk(clk), .reset(reset), .set(set), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dst_ok(dst_ok), .readin(readin), .din_1(din_1), .din_2(din_2),
    .index(index), .k(k), .full_in(full_in), .busy(busy), .done(done)
  );

  // Monitor: record completed writes and full_in cycles that advance the FSM.
  always @(negedge clk) begin
    if (!reset) begin
      if (readin && dst_ok && set) wr_q.push_back({din_1, din_2, index, k});
      if (full_in && set) full_cnt++;
      if (busy && s_valid && set && !s_ready) stall_cnt++;
    end
  end

  // Reference: pair j is (src[2j], src[2j+1]) at index 2j mod N in poly j/(N/2).
  task automatic build_exp();
    wr_t e;
    exp_q.delete();
    for (int j = 0; j < NP; j++) begin
      e.a   = src[2*j];
      e.b   = src[2*j+1];
      e.idx = DEPTH'((2*j) % N);
      e.kk  = 4'(j / (N/2));
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NC; i++) src[i] = 16'($urandom);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NC; i++) src[i] = 16'(i);
  endtask

  // One clock: drive at posedge+1, note the handshake at negedge.
  task automatic step(input bit v, input bit o, input bit st, input bit strt);
    s_valid = v;
    s_data  = (sent < NC) ? src[sent] : 16'h0;
    dst_ok  = o;
    set     = st;
    start   = strt;
    @(negedge clk);
    if (s_valid && s_ready) sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    wr_q.delete();
    full_cnt  = 0;
    stall_cnt = 0;
    sent      = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
  endtask

  // Feed coefficients up to limit with random valid/dst_ok/set percentages.
  task automatic feed(input int limit, input int pv, input int pd, input int ps,
                      input bit hold_start, input bit wait_done, output int cycles);
    int c = 0;
    while (c < 30000) begin
      step((sent < limit) && ($urandom_range(99) < pv),
           $urandom_range(99) < pd, $urandom_range(99) < ps, hold_start);
      c++;
      if (wait_done ? (done === 1'b1) : (sent >= limit)) break;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    cycles  = c;
  endtask

  task automatic test_reset();
    reset = 1'b1; set = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; dst_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, readin, busy, done, full_in, din_1, din_2, index, k} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rin=%b busy=%b done=%b full=%b d1=%h d2=%h idx=%0d k=%0d, expected all 0",
               s_ready, readin, busy, done, full_in, din_1, din_2, index, k);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int cyc;
    fill_ramp();
    build_exp();
    do_start();
    feed(NC, 100, 100, 100, 1'b0, 1'b1, cyc);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_done: got done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    checks++;
    if (full_cnt !== 1) begin
      errors++;
      $display("FAIL stream_full_pulse: got %0d full_in cycles, expected 1", full_cnt);
    end
    checks++;
    if (wr_q.size() != NP) begin
      errors++;
      $display("FAIL stream_count: got %0d writes, expected %0d", wr_q.size(), NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stream_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random();
    build_exp();
    do_start();
    feed(NC, 100, 100, 100, 1'b0, 1'b1, cyc);
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_s_ready: got %0d stalled cycles, expected 0", stall_cnt);
    end
    checks++;
    if (cyc !== NC + 2) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d cycles to done, expected %0d", cyc, NC + 2);
    end
    checks++;
    if (wr_q.size() != NP) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, expected %0d", wr_q.size(), NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    fill_random();
    build_exp();
    do_start();
    feed(20, 100, 100, 100, 1'b0, 1'b0, cyc);
    // Pair (18,19) at index 18 is now presented; hold dst_ok low for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = src[sent];
      dst_ok  = 1'b0;
      set     = 1'b1;
      @(negedge clk);
      checks++;
      if (readin !== 1'b1 || din_1 !== src[18] || din_2 !== src[19] || index !== DEPTH'(18) || k !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rin=%b d1=%h d2=%h idx=%0d k=%0d, expected rin=1 d1=%h d2=%h idx=18 k=0",
                 i, readin, din_1, din_2, index, k, src[18], src[19]);
      end
      checks++;
      if (s_ready !== (i == 0)) begin
        errors++;
        $display("FAIL bp_s_ready[%0d]: got %b, expected %b", i, s_ready, (i == 0));
      end
      if (s_valid && s_ready) sent++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (sent !== 21) begin
      errors++;
      $display("FAIL bp_buffered: got %0d accepted, expected 21", sent);
    end
    feed(NC, 100, 100, 100, 1'b0, 1'b1, cyc);
    checks++;
    if (wr_q.size() != NP || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_count: got %0d writes done=%b, expected %0d done=1", wr_q.size(), done, NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    fill_random();
    build_exp();
    do_start();
    // start held high through LOAD and FULL; it is dropped once DONE is seen.
    feed(NC, 80, 70, 100, 1'b1, 1'b1, cyc);
    checks++;
    if (done !== 1'b1 || full_cnt !== 1 || index !== DEPTH'(N-2) || k !== 4'(KK-1)) begin
      errors++;
      $display("FAIL start_ign_end: got done=%b full=%0d idx=%0d k=%0d, expected done=1 full=1 idx=%0d k=%0d",
               done, full_cnt, index, k, N-2, KK-1);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL start_ign_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (wr_q.size() != NP) begin
      errors++;
      $display("FAIL start_ign_count: got %0d writes, expected %0d", wr_q.size(), NP);
    end
    fill_random();
    build_exp();
    do_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || index !== '0 || k !== 4'd0 || readin !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b idx=%0d k=%0d rin=%b, expected 1 0 0 0 0",
               busy, done, index, k, readin);
    end
    feed(NC, 90, 90, 100, 1'b0, 1'b1, cyc);
    checks++;
    if (wr_q.size() != NP || done !== 1'b1) begin
      errors++;
      $display("FAIL restart_count: got %0d writes done=%b, expected %0d done=1", wr_q.size(), done, NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill_random();
    do_start();
    feed(301, 100, 100, 100, 1'b0, 1'b0, cyc);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({s_ready, readin, busy, done, full_in, din_1, din_2, index, k} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rdy=%b rin=%b busy=%b done=%b full=%b d1=%h d2=%h idx=%0d k=%0d, expected all 0",
               s_ready, readin, busy, done, full_in, din_1, din_2, index, k);
    end
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b1;
    set     = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_needs_start: got rdy=%b busy=%b, expected 0 0", s_ready, busy);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    fill_random();
    build_exp();
    do_start();
    feed(NC, 100, 100, 100, 1'b0, 1'b1, cyc);
    checks++;
    if (wr_q.size() != NP || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload_count: got %0d writes done=%b, expected %0d done=1", wr_q.size(), done, NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_reload_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_set_toggle();
    int cyc;
    fill_ramp();
    build_exp();
    do_start();
    feed(NC, 90, 100, 60, 1'b0, 1'b1, cyc);
    checks++;
    if (done !== 1'b1 || full_cnt !== 1) begin
      errors++;
      $display("FAIL set_toggle_end: got done=%b full=%0d, expected done=1 full=1", done, full_cnt);
    end
    checks++;
    if (wr_q.size() != NP) begin
      errors++;
      $display("FAIL set_toggle_count: got %0d writes, expected %0d", wr_q.size(), NP);
    end
    for (int i = 0; i < wr_q.size() && i < NP; i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL set_toggle_write[%0d]: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_set_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
